bcd2bin_entry: RTL
==================

Name: bcd2bin_entry

Overview:
- Sequential decimal-to-binary operand converter; the input-side counterpart of the binary-to-BCD and magnitude/sign display path.
- Takes a sign flag plus packed BCD digits and produces a signed two's-complement operand for the ALU.
- Uses iterative reverse double-dabble (shift right, subtract 3), one bit per clock, with a start/busy/done handshake.
- Sits between the user digit-entry logic (switches/buttons) and the ALU A/B operand registers.

Parameters:
- DIGITS, 2, number of BCD digits accepted (1..3).
- OUT_W, 8, width of the signed two's-complement result (>= 2).

Ports:
- clk  input  1  system clock, all state on rising edge.
- ar_n  input  1  asynchronous active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD digits, most significant digit in the top nibble.
- neg  input  1  1 = negative operand.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  single-cycle pulse; y and err are valid from that cycle on.
- y  output  OUT_W  signed result, held between conversions.
- err  output  1  last conversion failed (invalid digit or overflow); held until the next done.

Behaviour:
- Reset (ar_n=0, asynchronous): state=IDLE, y=0, err=0, busy=0, done=0; shift register and counter cleared. Reset during a conversion aborts it; no done is issued.
- States: IDLE, CHECK, SHIFT, SIGN, DONE.
- IDLE:
  - On start=1, capture bcd_in and neg into internal registers; go to CHECK.
  - Inputs are never sampled again until the next IDLE; changes to bcd_in/neg while busy are ignored.
- CHECK (1 cycle):
  - Any captured nibble > 9 → set pending error flag; go to DONE.
  - Otherwise load work register {bcd, bin} = {digits, 0}, counter=0; go to SHIFT.
- SHIFT (exactly 4*DIGITS cycles): each cycle:
  - shift {bcd, bin} right one bit;
  - then, for every BCD nibble whose shifted value is >= 8, subtract 3;
  - counter+1; after the 4*DIGITS-th shift, go to SIGN.
  - Magnitude mag = bin, width 4*DIGITS bits.
- SIGN (1 cycle): overflow if
  - neg=0 and mag > 2^(OUT_W-1)-1, or
  - neg=1 and mag > 2^(OUT_W-1).
  - No overflow: result = neg ? (0 - mag) : mag, truncated to OUT_W. Go to DONE.
- DONE (1 cycle):
  - done=1, busy=0.
  - On success: y updated with the result, err=0.
  - On error without the optional feature: y keeps its previous value, err=1.
  - Returns to IDLE. A start asserted in the DONE cycle is ignored; the next start must come in IDLE.
- busy=1 in CHECK, SHIFT and SIGN.
- Latency from the start-sampling edge:
  - done rises 4*DIGITS+3 edges later (11 for DIGITS=2).
  - Invalid digit: 2 edges.
- Negative zero (neg=1, mag=0) yields y=0, err=0.
- start held high continuously causes back-to-back conversions with one IDLE cycle between them.

Optional Feature:
- Macro BCD2BIN_SAT_EN.
- Defined: on overflow, y saturates to 2^(OUT_W-1)-1 (positive) or -2^(OUT_W-1) (negative) and err=0. Invalid digits still set err=1 and hold y.
- Undefined: overflow behaves as an error (y held, err=1).
- Adds no latency either way.

Test Plan:
- DIGITS=2, OUT_W=8: bcd_in=8'h42, neg=0, start → done after 11 cycles, y=8'h2A, err=0; busy high for the 10 cycles before done.
- DIGITS=2: bcd_in=8'h99, neg=1 → y=8'h9D (-99), err=0. Then bcd_in=8'h00, neg=1 → y=8'h00.
- DIGITS=2: bcd_in=8'hA5 → done 2 cycles after start, err=1, y unchanged from the previous conversion (8'h00).
- DIGITS=3, OUT_W=8: 12'h128 neg=1 → y=8'h80. 12'h200 neg=0 → err=1, y held; with BCD2BIN_SAT_EN → y=8'h7F, err=0.
- DIGITS=2: start 8'h42, change bcd_in to 8'h17 and pulse start at cycle 4 → only one done, y=8'h2A.
- DIGITS=2: start 8'h55, pull ar_n low at cycle 5 → all outputs 0 immediately, no done. After release, a new 8'h07 conversion gives y=8'h07.

Source files
------------

// File: rtl/bcd2bin_entry.sv
// Reverse double-dabble BCD -> signed binary, one bit per clock; done 4*DIGITS+3 cycles after start (2 on a bad digit).
// start is taken only when idle, otherwise ignored; define BCD2BIN_SAT_EN to saturate on overflow instead of raising err.
module bcd2bin_entry #(
    parameter int DIGITS = 2,
    parameter int OUT_W  = 8
) (
    input  logic                  clk,
    input  logic                  ar_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  neg,
    output logic                  busy,
    output logic                  done,
    output logic [OUT_W-1:0]      y,
    output logic                  err
);

    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(BW);
    localparam int CW    = ((BW > OUT_W) ? BW : OUT_W) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SHIFT,
        S_SIGN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BW-1:0]       r_bcd;
    logic                r_neg;
    logic [2*BW-1:0]     r_work;
    logic [CNT_W-1:0]    r_cnt;
    logic [OUT_W-1:0]    r_res;
    logic                r_err_pend;
    logic [OUT_W-1:0]    r_y;
    logic                r_err;
    logic                r_busy;
    logic                r_done;

    logic                w_bad_digit;
    logic                w_shift_last;
    logic [2*BW-1:0]     w_work_sh;
    logic [CW-1:0]       w_mag_ext;
    logic [CW-1:0]       w_half;
    logic                w_ovf;
    logic [OUT_W-1:0]    w_mag_trunc;
    logic [OUT_W-1:0]    w_res_raw;
    logic [OUT_W-1:0]    w_res_fin;
    logic                w_err_fin;

    always_comb begin
        w_bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] > 4'd9) begin
                w_bad_digit = 1'b1;
            end
        end
    end

    // One reverse double-dabble step: shift the whole word, then correct any BCD nibble that reached 8 or more.
    always_comb begin
        w_work_sh = r_work >> 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_work_sh[BW + 4*i + 3]) begin
                w_work_sh[BW + 4*i +: 4] = w_work_sh[BW + 4*i +: 4] - 4'd3;
            end
        end
    end

    assign w_shift_last = (r_cnt == CNT_W'(BW - 1));

    always_comb begin
        w_mag_ext           = {{(CW-BW){1'b0}}, r_work[BW-1:0]};
        w_half              = '0;
        w_half[OUT_W-1]     = 1'b1;
        // Negative range reaches one step further than positive.
        w_ovf               = r_neg ? (w_mag_ext > w_half) : (w_mag_ext >= w_half);
        w_mag_trunc         = w_mag_ext[OUT_W-1:0];
        w_res_raw           = r_neg ? ({OUT_W{1'b0}} - w_mag_trunc) : w_mag_trunc;
        w_res_fin           = w_res_raw;
        w_err_fin           = 1'b0;
`ifdef BCD2BIN_SAT_EN
        if (w_ovf) begin
            w_res_fin = r_neg ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
`else
        w_err_fin = w_ovf;
`endif
    end

    always_ff @(posedge clk or negedge ar_n) begin
        if (!ar_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CHECK;
            S_CHECK: w_state_nxt = w_bad_digit ? S_DONE : S_SHIFT;
            S_SHIFT: if (w_shift_last) w_state_nxt = S_SIGN;
            S_SIGN:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge ar_n) begin
        if (!ar_n) begin
            r_bcd      <= '0;
            r_neg      <= 1'b0;
            r_work     <= '0;
            r_cnt      <= '0;
            r_res      <= '0;
            r_err_pend <= 1'b0;
            r_y        <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_busy <= (r_state == S_CHECK) || (r_state == S_SHIFT) || (r_state == S_SIGN);
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bcd <= bcd_in;
                        r_neg <= neg;
                    end
                end
                S_CHECK: begin
                    r_err_pend <= w_bad_digit;
                    if (!w_bad_digit) begin
                        r_work <= {r_bcd, {BW{1'b0}}};
                        r_cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    r_work <= w_work_sh;
                    r_cnt  <= r_cnt + 1'b1;
                end
                S_SIGN: begin
                    r_res      <= w_res_fin;
                    r_err_pend <= w_err_fin;
                end
                S_DONE: begin
                    // A failed conversion leaves the previous operand in place.
                    if (!r_err_pend) begin
                        r_y <= r_res;
                    end
                    r_err <= r_err_pend;
                end
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign y    = r_y;
    assign err  = r_err;

endmodule
